avr_prefetch: RTL and testbench

Instruction prefetch queue between program memory and the fetch/decode stage of the AVR core. Issues sequential program-memory reads ahead of consumption, buffers up to `DEPTH` words with their word addresses, and presents one complete instruction per handshake. It recognises two-word instructions (JMP, CALL, LDS, STS) and presents both words together. Redirects (jumps, calls, returns) arrive as a flush carrying the new PC.

---
 rtl/avr_pkg.sv | 26 ++
 rtl/avr_prefetch_fifo.sv | 70 +++++++
 rtl/avr_prefetch.sv | 91 +++++++++
 tb/tb_avr_prefetch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_pkg.sv
// Shared AVR core definitions: program-counter width, NOP encoding and the
// two-word opcode recogniser used by both the prefetch queue and the decoder.
package avr_pkg;

  localparam int PC_W = 16;

  localparam logic [15:0] NOP = 16'h0000;

  localparam logic [15:0] JMP_MASK  = 16'hFE0E;
  localparam logic [15:0] JMP_VAL   = 16'h940C;
  localparam logic [15:0] CALL_MASK = 16'hFE0E;
  localparam logic [15:0] CALL_VAL  = 16'h940E;
  localparam logic [15:0] LDS_MASK  = 16'hFE0F;
  localparam logic [15:0] LDS_VAL   = 16'h9000;
  localparam logic [15:0] STS_MASK  = 16'hFE0F;
  localparam logic [15:0] STS_VAL   = 16'h9200;

  // JMP, CALL, LDS and STS carry a second word (address or constant).
  function automatic logic is_two_word(input logic [15:0] word);
    return ((word & JMP_MASK)  == JMP_VAL)  ||
           ((word & CALL_MASK) == CALL_VAL) ||
           ((word & LDS_MASK)  == LDS_VAL)  ||
           ((word & STS_MASK)  == STS_VAL);
  endfunction

endpackage

// File: rtl/avr_prefetch_fifo.sv
// Circular buffer of {word, pc} entries with one write port, head and head+1
// read ports, and pop-by-0/1/2. Synchronous clear, asynchronous reset.
module avr_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16,
  localparam int IW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            clr_i,
  input  logic            wr_en_i,
  input  logic [15:0]     wr_word_i,
  input  logic [PC_W-1:0] wr_pc_i,
  input  logic [1:0]      pop_n_i,
  output logic [15:0]     head_word_o,
  output logic [PC_W-1:0] head_pc_o,
  output logic [15:0]     next_word_o,
  output logic [CW-1:0]   count_o
);

  logic [15:0]     word_q [DEPTH];
  logic [PC_W-1:0] pc_q   [DEPTH];
  logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  // Index advance modulo DEPTH, so non-power-of-two depths also wrap cleanly.
  function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] idx, input logic [1:0] n);
    int unsigned s;
    s = 32'(idx) + 32'(n);
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return IW'(s);
  endfunction

  always_comb begin
    head_d  = idx_add(head_q, pop_n_i);
    tail_d  = wr_en_i ? idx_add(tail_q, 2'd1) : tail_q;
    count_d = count_q - CW'(pop_n_i) + CW'(wr_en_i);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en_i) begin
        word_q[tail_q] <= wr_word_i;
        pc_q[tail_q]   <= wr_pc_i;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_word_o = word_q[head_q];
  assign head_pc_o   = pc_q[head_q];
  assign next_word_o = word_q[idx_add(head_q, 2'd1)];
  assign count_o     = count_q;

endmodule

// File: rtl/avr_prefetch.sv
// AVR instruction prefetch queue: credit-limited sequential reads ahead of the
// decoder, two-word instruction pairing, and flush-driven redirects.
module avr_prefetch
  import avr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = avr_pkg::PC_W
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            pm_rd,
  output logic [PC_W-1:0] pm_addr,
  input  logic [15:0]     pm_data,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [15:0]     instr,
  output logic [15:0]     instr_ext,
  output logic            instr_is32,
  output logic [PC_W-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: the head instruction is transferred in a cycle where
  // instr_valid and instr_ready are both high and flush is low; valid never
  // depends on ready, and the head stays stable until it is accepted.

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, issue_pc_q;
  logic            inflight_q, squash_q, squash_d;
  logic            issue, push, accept;
  logic [1:0]      pop_n;
  logic [15:0]     head_word, next_word;
  logic [PC_W-1:0] head_pc;
  logic [CW-1:0]   count;

  always_comb begin
    // Buffered entries plus the outstanding read never exceed DEPTH, so every
    // response has a slot waiting for it.
    issue       = !flush && ((32'(count) + 32'(inflight_q)) < 32'(DEPTH));
    push        = inflight_q && !squash_q && !flush;
    instr_is32  = is_two_word(head_word);
    instr_valid = 32'(count) >= (instr_is32 ? 32'd2 : 32'd1);
    accept      = instr_valid && instr_ready && !flush;
    pop_n       = accept ? (instr_is32 ? 2'd2 : 2'd1) : 2'd0;
    squash_d    = flush && inflight_q;
    fetch_pc_d  = fetch_pc_q;
    if (flush)      fetch_pc_d = flush_pc;
    else if (issue) fetch_pc_d = fetch_pc_q + PC_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc_q <= '0;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      squash_q   <= squash_d;
      if (issue) issue_pc_q <= fetch_pc_q;
    end
  end

  avr_prefetch_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .clr_i       (flush),
    .wr_en_i     (push),
    .wr_word_i   (pm_data),
    .wr_pc_i     (issue_pc_q),
    .pop_n_i     (pop_n),
    .head_word_o (head_word),
    .head_pc_o   (head_pc),
    .next_word_o (next_word),
    .count_o     (count)
  );

  // Reset gates the strobe directly so it drops without waiting for an edge.
  assign pm_rd     = issue && RST_N;
  assign pm_addr   = fetch_pc_q;
  assign instr     = head_word;
  assign instr_pc  = head_pc;
  assign instr_ext = instr_is32 ? next_word : NOP;

endmodule

// File: tb/tb_avr_prefetch.sv
// Bench for avr_prefetch: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a queue-based model.
module tb_avr_prefetch;

  localparam int DEPTH = 4;
  localparam int PC_W  = 16;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic            pm_rd;
  logic [PC_W-1:0] pm_addr;
  logic [15:0]     pm_data;
  logic            flush;
  logic [PC_W-1:0] flush_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [15:0]     instr;
  logic [15:0]     instr_ext;
  logic            instr_is32;
  logic [PC_W-1:0] instr_pc;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  avr_prefetch #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .pm_rd       (pm_rd),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_ext   (instr_ext),
    .instr_is32  (instr_is32),
    .instr_pc    (instr_pc)
  );

  // ---------------- model and scoreboard state ----------------
  logic [15:0]     rom [0:65535];
  logic [31:0]     exp_q[$];          // {pc, word} in program order
  logic [PC_W-1:0] m_fetch_pc, m_infl_pc;
  bit              m_infl;
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  int              n_checks = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              pc3_seen = 0;
  logic [PC_W-1:0] acc_log[$];

  logic            obs_rd    [64];
  logic [PC_W-1:0] obs_addr  [64];
  logic            obs_valid [64];
  logic [PC_W-1:0] obs_pc    [64];
  logic [15:0]     obs_instr [64];
  logic [15:0]     obs_ext   [64];
  logic            obs_is32  [64];

  function automatic bit m_is32(input logic [15:0] w);
    return (w ==? 16'b1001_010?_????_110?) || (w ==? 16'b1001_010?_????_111?) ||
           (w ==? 16'b1001_000?_????_0000) || (w ==? 16'b1001_001?_????_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_fetch_pc = '0;
    m_infl_pc  = '0;
    m_infl     = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called just after a rising edge with inputs already set for this cycle.
  // Compares at the falling edge, advances the model, then plays memory.
  task automatic cycle();
    logic        exp_rd, exp_valid, head32;
    logic [31:0] h0, h1;
    int          need;
    @(negedge CLK);
    h0 = '0;
    h1 = '0;
    head32 = 1'b0;
    if (exp_q.size() > 0) begin
      h0 = exp_q[0];
      head32 = m_is32(h0[15:0]);
    end
    need = head32 ? 2 : 1;
    exp_valid = (exp_q.size() >= need);
    exp_rd = !flush && ((exp_q.size() + int'(m_infl)) < DEPTH);

    check("pm_rd", pm_rd, exp_rd);
    if (exp_rd) check("pm_addr", pm_addr, m_fetch_pc);
    check("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      if (head32) h1 = exp_q[1];
      check("instr", instr, h0[15:0]);
      check("instr_pc", instr_pc, h0[31:16]);
      check("instr_is32", instr_is32, head32);
      check("instr_ext", instr_ext, head32 ? h1[15:0] : 16'h0000);
    end

    if (cyc < 64) begin
      obs_rd[cyc]    = pm_rd;
      obs_addr[cyc]  = pm_addr;
      obs_valid[cyc] = instr_valid;
      obs_pc[cyc]    = instr_pc;
      obs_instr[cyc] = instr;
      obs_ext[cyc]   = instr_ext;
      obs_is32[cyc]  = instr_is32;
    end
    if (instr_valid && instr_pc == 16'h0003) pc3_seen++;
    if (instr_valid && instr_ready && !flush) acc_log.push_back(instr_pc);
    mem_rd   = pm_rd;
    mem_addr = pm_addr;

    if (flush) begin
      exp_q.delete();
      m_fetch_pc = flush_pc;
      m_infl     = 1'b0;
    end else begin
      if (exp_valid && instr_ready) repeat (need) void'(exp_q.pop_front());
      if (m_infl) exp_q.push_back({m_infl_pc, rom[m_infl_pc]});
      if (exp_rd) begin
        m_infl_pc  = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 16'd1;
      end
      m_infl = exp_rd;
    end

    @(posedge CLK);
    #1;
    pm_data = mem_rd ? rom[mem_addr] : 16'($urandom);
    cyc++;
  endtask

  task automatic run(input int n, input logic rdy);
    flush = 1'b0;
    instr_ready = rdy;
    repeat (n) cycle();
  endtask

  task automatic do_flush(input logic [PC_W-1:0] pc, input logic rdy);
    flush = 1'b1;
    flush_pc = pc;
    instr_ready = rdy;
    cycle();
    flush = 1'b0;
  endtask

  // Drops reset off-edge, checks the reset values at once, releases off-edge.
  task automatic apply_reset(input string tag);
    #2;
    RST_N = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b0;
    #1;
    check({tag, " rst pm_rd"}, pm_rd, 1'b0);
    check({tag, " rst instr_valid"}, instr_valid, 1'b0);
    check({tag, " rst instr"}, instr, 16'h0000);
    check({tag, " rst instr_ext"}, instr_ext, 16'h0000);
    check({tag, " rst instr_is32"}, instr_is32, 1'b0);
    check({tag, " rst instr_pc"}, instr_pc, 16'h0000);
    repeat (2) @(posedge CLK);
    #1;
    m_reset();
    RST_N = 1'b1;
    cyc = 0;
    pc3_seen = 0;
    acc_log.delete();
  endtask

  task automatic load_directed_rom();
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
    rom[0] = 16'hE00F;
    rom[5] = 16'h940C;
    rom[6] = 16'h0123;
    for (int i = 0; i < 8; i++) rom[16'h0040 + i] = 16'h1000 + 16'(i);
    rom[16'hFFFF] = 16'hE001;
  endtask

  task automatic load_random_rom();
    logic [15:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rom[i] = 16'h940C | (w & 16'h01F1);
        1: rom[i] = 16'h940E | (w & 16'h01F1);
        2: rom[i] = 16'h9000 | (w & 16'h01F0);
        3: rom[i] = 16'h9200 | (w & 16'h01F0);
        default: rom[i] = w;
      endcase
    end
  endtask

  // ---------------- stimulus and final report ----------------
  initial begin
    flush = 1'b0;
    flush_pc = '0;
    instr_ready = 1'b0;
    pm_data = 16'h0000;
    m_reset();
    load_directed_rom();

    // Reset release into a free-running stream.
    apply_reset("p1");
    run(12, 1'b1);
    check("p1 rd c0", obs_rd[0], 1'b1);
    for (int i = 0; i < 4; i++) check("p1 addr seq", obs_addr[i], 16'(i));
    check("p1 valid c1", obs_valid[1], 1'b0);
    check("p1 valid c2", obs_valid[2], 1'b1);
    check("p1 instr c2", obs_instr[2], 16'hE00F);
    check("p1 pc c2", obs_pc[2], 16'h0000);
    for (int i = 3; i < 7; i++) check("p1 pc stream", obs_pc[i], 16'(i - 2));
    check("p1 valid half jmp", obs_valid[7], 1'b0);
    check("p1 jmp pc", obs_pc[8], 16'h0005);
    check("p1 jmp is32", obs_is32[8], 1'b1);
    check("p1 jmp ext", obs_ext[8], 16'h0123);
    check("p1 after jmp pc", obs_pc[9], 16'h0007);

    // Backpressure: four reads fill the queue, then drain in order.
    apply_reset("p2");
    run(8, 1'b0);
    begin
      int nrd;
      nrd = 0;
      for (int i = 0; i < 8; i++) nrd += int'(obs_rd[i]);
      check("p2 reads while stalled", nrd, 4);
    end
    for (int i = 0; i < 4; i++) check("p2 addr seq", obs_addr[i], 16'(i));
    check("p2 rd stalled c7", obs_rd[7], 1'b0);
    run(16, 1'b1);
    check("p2 valid c8", obs_valid[8], 1'b1);
    check("p2 pc c8", obs_pc[8], 16'h0000);
    check("p2 rd c8", obs_rd[8], 1'b0);
    check("p2 rd c9", obs_rd[9], 1'b1);
    check("p2 addr c9", obs_addr[9], 16'h0004);
    check("p2 accept count", acc_log.size() >= 7, 1'b1);
    if (acc_log.size() >= 7) begin
      for (int i = 0; i < 6; i++) check("p2 accept order", acc_log[i], 16'(i));
      check("p2 accept after jmp", acc_log[6], 16'h0007);
    end

    // Flush with a read in flight, then a head-only two-word, then wrap.
    apply_reset("p3");
    run(4, 1'b1);
    do_flush(16'h0040, 1'b1);
    run(8, 1'b1);
    check("p3 rd in flush", obs_rd[4], 1'b0);
    check("p3 rd N+1", obs_rd[5], 1'b1);
    check("p3 addr N+1", obs_addr[5], 16'h0040);
    check("p3 valid N+1", obs_valid[5], 1'b0);
    check("p3 valid N+2", obs_valid[6], 1'b0);
    check("p3 valid N+3", obs_valid[7], 1'b1);
    check("p3 pc N+3", obs_pc[7], 16'h0040);
    check("p3 pc N+4", obs_pc[8], 16'h0041);
    check("p3 accept in flush ignored", acc_log.size() >= 3 ? acc_log[2] : 16'hDEAD, 16'h0040);
    do_flush(16'h0005, 1'b1);
    run(6, 1'b1);
    check("p3 pc3 never shown", pc3_seen, 0);
    check("p3 half jmp valid", obs_valid[16], 1'b0);
    check("p3 jmp valid", obs_valid[17], 1'b1);
    check("p3 jmp pc", obs_pc[17], 16'h0005);
    check("p3 jmp is32", obs_is32[17], 1'b1);
    check("p3 jmp ext", obs_ext[17], 16'h0123);
    check("p3 after jmp pc", obs_pc[18], 16'h0007);
    do_flush(16'hFFFF, 1'b1);
    run(6, 1'b1);
    check("p4 addr wrap a", obs_addr[21], 16'hFFFF);
    check("p4 addr wrap b", obs_addr[22], 16'h0000);
    check("p4 pc wrap a", obs_pc[23], 16'hFFFF);
    check("p4 pc wrap b", obs_pc[24], 16'h0000);
    check("p4 instr wrap b", obs_instr[24], 16'hE00F);

    // Randomized program, readiness and redirects, with one async reset.
    load_random_rom();
    apply_reset("p5");
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        run(1, 1'b1);
        #3;
        RST_N = 1'b0;
        #1;
        check("p5 async pm_rd", pm_rd, 1'b0);
        check("p5 async instr_valid", instr_valid, 1'b0);
        check("p5 async instr", instr, 16'h0000);
        repeat (2) @(posedge CLK);
        #1;
        m_reset();
        RST_N = 1'b1;
      end
      instr_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 31) == 0);
      flush_pc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                               : 16'($urandom);
      cycle();
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
